// File: rtl/bg_mosaic_hold.sv
// Per-BG horizontal mosaic pixel hold plus registered, mosaic-adjusted line numbers.
// Define MOSAIC_YOFS_EN to build the vertical line-offset subtraction; otherwise bg_yofs mirrors vcount.
module bg_mosaic_hold (
   input  logic        clk,
   input  logic        reset,
   input  logic        dot_en,
   input  logic        period_start,
   input  logic        pixel_strobe,
   input  logic [3:0]  yofs_subtract,
   input  logic [3:0]  mosaic_en,
   input  logic [8:0]  vcount,
   input  logic [35:0] bg_pix_in,
   output logic [35:0] bg_pix_out,
   output logic [35:0] bg_yofs
);

   logic [35:0] pix_q;
   logic [35:0] yofs_q;
   logic [35:0] yofs_next;

`ifdef MOSAIC_YOFS_EN
   logic [8:0] ys_ext;
   logic [8:0] vcount_adj;

   // Clamp at zero so the top lines of a mosaic block never wrap to the bottom of the frame.
   always_comb begin
      ys_ext     = {5'd0, yofs_subtract};
      vcount_adj = (ys_ext > vcount) ? 9'd0 : (vcount - ys_ext);
      yofs_next  = '0;
      for (int n = 0; n < 4; n++) begin
         yofs_next[9*n +: 9] = mosaic_en[n] ? vcount_adj : vcount;
      end
   end
`else
   logic unused_yofs_subtract;
   assign unused_yofs_subtract = ^yofs_subtract;

   always_comb begin
      yofs_next = '0;
      for (int n = 0; n < 4; n++) begin
         yofs_next[9*n +: 9] = vcount;
      end
   end
`endif

   // period_start forces a capture so a line never starts with the previous line's held pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_q  <= '0;
         yofs_q <= '0;
      end else if (dot_en) begin
         yofs_q <= yofs_next;
         for (int n = 0; n < 4; n++) begin
            if (!mosaic_en[n] || pixel_strobe || period_start) begin
               pix_q[9*n +: 9] <= bg_pix_in[9*n +: 9];
            end
         end
      end
   end

   assign bg_pix_out = pix_q;
   assign bg_yofs    = yofs_q;

endmodule

// File: tb/tb_bg_mosaic_hold.sv
// Scoreboard bench for bg_mosaic_hold; expectations follow MOSAIC_YOFS_EN the same way the build does.
module tb_bg_mosaic_hold;

   logic        clk;
   logic        reset;
   logic        dot_en;
   logic        period_start;
   logic        pixel_strobe;
   logic [3:0]  yofs_subtract;
   logic [3:0]  mosaic_en;
   logic [8:0]  vcount;
   logic [35:0] bg_pix_in;
   logic [35:0] bg_pix_out;
   logic [35:0] bg_yofs;

   int compared;
   int mismatched;

`ifdef MOSAIC_YOFS_EN
   localparam bit YOFS_ON = 1'b1;
`else
   localparam bit YOFS_ON = 1'b0;
`endif

   logic [35:0] m_pix;
   logic [35:0] m_yofs;
   logic [71:0] exp_q[$];

   bg_mosaic_hold dut (
      .clk           (clk),
      .reset         (reset),
      .dot_en        (dot_en),
      .period_start  (period_start),
      .pixel_strobe  (pixel_strobe),
      .yofs_subtract (yofs_subtract),
      .mosaic_en     (mosaic_en),
      .vcount        (vcount),
      .bg_pix_in     (bg_pix_in),
      .bg_pix_out    (bg_pix_out),
      .bg_yofs       (bg_yofs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [35:0] rand_pix();
      return {4'($urandom()), $urandom()};
   endfunction

   function automatic logic [8:0] exp_yofs(input logic en, input logic [3:0] ys, input logic [8:0] vc);
      if (YOFS_ON && en) begin
         if (int'(ys) > int'(vc)) return 9'd0;
         return 9'(int'(vc) - int'(ys));
      end
      return vc;
   endfunction

   task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle, advance the reference, then compare registered outputs just after the edge.
   task automatic applyStimulus(input string tag, input logic rs, input logic de, input logic ps,
                                input logic st, input logic [3:0] ys, input logic [3:0] me,
                                input logic [8:0] vc, input logic [35:0] pin);
      logic [71:0] exp_val;
      @(negedge clk);
      reset = rs; dot_en = de; period_start = ps; pixel_strobe = st;
      yofs_subtract = ys; mosaic_en = me; vcount = vc; bg_pix_in = pin;
      if (rs) begin
         m_pix = '0;
         m_yofs = '0;
      end else if (de) begin
         for (int n = 0; n < 4; n++) begin
            if (!me[n] || st || ps) m_pix[9*n +: 9] = pin[9*n +: 9];
            m_yofs[9*n +: 9] = exp_yofs(me[n], ys, vc);
         end
      end
      exp_q.push_back({m_pix, m_yofs});
      @(posedge clk);
      #1;
      exp_val = exp_q.pop_front();
      checkOutput(tag, {bg_pix_out, bg_yofs}, exp_val);
   endtask

   initial begin
      logic [35:0] pin;
      compared = 0;
      mismatched = 0;
      m_pix = '0;
      m_yofs = '0;
      reset = 1'b1; dot_en = 1'b0; period_start = 1'b0; pixel_strobe = 1'b0;
      yofs_subtract = '0; mosaic_en = '0; vcount = '0; bg_pix_in = '0;

      applyStimulus("reset0", 1, 0, 0, 0, 4'd3, 4'hF, 9'd10, 36'hFFFFFFFFF);
      applyStimulus("reset1", 1, 1, 1, 1, 4'd3, 4'hF, 9'd10, 36'hFFFFFFFFF);

      // Mosaic off: BG1 ramps and must appear one dot later.
      for (int i = 0; i < 8; i++) begin
         pin = rand_pix();
         pin[8:0] = 9'(i + 1);
         applyStimulus("ramp", 0, 1, 0, 0, 4'd2, 4'h0, 9'(20 + i), pin);
         checkOutput("ramp_bg1", 72'(bg_pix_out[8:0]), 72'(i + 1));
      end

      // BG1 mosaic, strobe every fourth dot.
      for (int i = 0; i < 8; i++) begin
         pin = rand_pix();
         pin[8:0] = 9'(16 + i);
         applyStimulus("mosaic4", 0, 1, i == 0, (i % 4) == 0, 4'd1, 4'h1, 9'd50, pin);
         checkOutput("mosaic4_bg1", 72'(bg_pix_out[8:0]), 72'(16 + 4 * (i / 4)));
      end

      // All mosaic: hold through unstrobed dots, then period_start forces capture.
      applyStimulus("all_load", 0, 1, 0, 1, 4'd0, 4'hF, 9'd60, rand_pix());
      applyStimulus("all_hold", 0, 1, 0, 0, 4'd0, 4'hF, 9'd60, rand_pix());
      applyStimulus("all_ps", 0, 1, 1, 0, 4'd0, 4'hF, 9'd61, {4{9'h1AB}});
      checkOutput("all_ps_const", 72'(bg_pix_out), 72'({4{9'h1AB}}));

      // Vertical adjustment on BG2 only, including clamp and exact-zero cases.
      applyStimulus("yofs_37_5", 0, 1, 0, 1, 4'd5, 4'h2, 9'd37, rand_pix());
      checkOutput("yofs_bg2_37_5", 72'(bg_yofs[17:9]), YOFS_ON ? 72'd32 : 72'd37);
      checkOutput("yofs_bg1_37_5", 72'(bg_yofs[8:0]), 72'd37);
      applyStimulus("yofs_3_7", 0, 1, 0, 0, 4'd7, 4'h2, 9'd3, rand_pix());
      checkOutput("yofs_bg2_3_7", 72'(bg_yofs[17:9]), YOFS_ON ? 72'd0 : 72'd3);
      applyStimulus("yofs_7_7", 0, 1, 0, 0, 4'd7, 4'h2, 9'd7, rand_pix());
      applyStimulus("yofs_15_300", 0, 1, 0, 0, 4'd15, 4'h2, 9'd300, rand_pix());

      // dot_en gating: strobe held high, state may only move on enabled cycles.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) begin
            applyStimulus("gate_off", 0, 0, 0, 1, 4'd3, 4'(i * 5), 9'(100 + j), rand_pix());
         end
         applyStimulus("gate_on", 0, 1, 0, 1, 4'd3, 4'(i * 5), 9'(110 + i), rand_pix());
      end

      // Reset mid-block: BG1 stays zero until the next strobe.
      applyStimulus("rst_load", 0, 1, 0, 1, 4'd0, 4'h1, 9'd80, rand_pix());
      applyStimulus("rst_hold", 0, 1, 0, 0, 4'd0, 4'h1, 9'd80, rand_pix());
      applyStimulus("rst_pulse", 1, 0, 0, 0, 4'd0, 4'h1, 9'd80, rand_pix());
      checkOutput("rst_zero", 72'({bg_pix_out, bg_yofs}), 72'd0);
      applyStimulus("rst_after0", 0, 1, 0, 0, 4'd0, 4'h1, 9'd81, rand_pix());
      checkOutput("rst_bg1_held0", 72'(bg_pix_out[8:0]), 72'd0);
      applyStimulus("rst_after1", 0, 1, 0, 0, 4'd0, 4'h1, 9'd81, rand_pix());
      pin = rand_pix();
      pin[8:0] = 9'h15A;
      applyStimulus("rst_strobe", 0, 1, 0, 1, 4'd0, 4'h1, 9'd82, pin);
      checkOutput("rst_bg1_load", 72'(bg_pix_out[8:0]), 72'h15A);

      // Random mix including mid-block enable changes and occasional reset.
      for (int i = 0; i < 60; i++) begin
         applyStimulus("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                       4'($urandom()), 4'($urandom()), 9'($urandom()), rand_pix());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
